clk_period_monitor: RTL and testbench
=====================================

# clk_period_monitor

Measures the half-period of a slow square wave, such as the divided pattern clock from the 5 MHz divider, in the fast system-clock domain. It checks each measurement against an expected value and reports lock, timeout and tolerance faults. It sits beside the pattern generator as the receiving-side checker of the divided clock, feeding status to the BLDC controller supervisor.

## Interface
Parameters:
- EXP_HALF, 5: expected half-period in clk cycles.
- TOL, 0: allowed deviation, inclusive, in cycles.
- LOCK_CNT, 4: consecutive in-tolerance measurements required for lock (≥1).
- TIMEOUT, 1023: cycles without an edge before timeout (> EXP_HALF+TOL).
- CNT_W, 32: counter and measurement width.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-low reset.
- sig_in  in  1  square wave under test.
- clr_fault  in  1  clears sticky fault.
- half_period  out  CNT_W  last measured half-period; reset 0.
- period_valid  out  1  one-cycle pulse when half_period updates; reset 0.
- edge_pulse  out  1  one-cycle pulse per detected edge (either polarity); reset 0.
- locked  out  1  lock status; reset 0.
- fault  out  1  sticky fault flag; reset 0.

## Operation
- Edge detection: the sampled signal s is compared with its registered previous value s_prev. An edge is any cycle where s != s_prev. s_prev resets to 0.
- Interval counter cnt:
  - Cleared to 0 on an edge cycle, otherwise increments.
  - Saturates at TIMEOUT.
  - Measurement = cnt+1 at an edge. A toggle every 5 cycles measures 5.
- In-tolerance test: |meas − EXP_HALF| ≤ TOL, computed with a (CNT_W+1)-bit signed difference. No wrap.
- FSM states: SEARCH, MEASURE, LOCKED; reset state SEARCH.
  - SEARCH: the first edge moves to MEASURE. The interval before it is partial, so there is no measurement and no period_valid.
  - MEASURE: each edge produces a measurement and a period_valid pulse.
    - In-tolerance increments match_cnt.
    - Out-of-tolerance clears match_cnt and does not set fault.
    - When match_cnt reaches LOCK_CNT, go to LOCKED.
  - LOCKED: out-of-tolerance sets fault, clears match_cnt and returns to MEASURE.
  - Any state: cnt reaching TIMEOUT sets fault (except in SEARCH), clears match_cnt and goes to SEARCH.
- locked is 1 exactly while the state is LOCKED.
- fault is sticky until clr_fault or reset. If a set and clr_fault occur in the same cycle, the set wins.
- Simultaneous events: an edge in the same cycle that cnt would reach TIMEOUT is a valid edge; no timeout occurs.
- Reset mid-measurement: all state returns to reset values on the next posedge, and the partial interval is discarded.

## Timing
- All outputs are registered.
- With the synchronizer compiled in: edge_pulse and period_valid assert 3 cycles after the first clk edge that samples the new sig_in level.
- Without the synchronizer: latency is 1 cycle.
- period_valid and edge_pulse coincide for measured edges.
- locked rises in the same cycle as the LOCK_CNT-th in-tolerance period_valid.
- Timeout fault and SEARCH entry occur in the cycle after cnt reaches TIMEOUT.
- half_period holds its value between pulses and is not cleared by timeout.

## Configuration
- CLK_PERIOD_MONITOR_SYNC_EN:
  - Defined: sig_in passes through a 2-flop synchronizer (reset 0) before edge detection. This is safe for asynchronous sources.
  - Undefined: sig_in is used directly, and must be synchronous to clk.

## Structure
- Shared package clk_mon_pkg:
  - FSM state enum (SEARCH, MEASURE, LOCKED).
  - Default width constant CNT_W_DEF = 32.
- One natural sub-module, sync_edge_det. It holds the optional synchronizer plus the s_prev register and outputs s and the edge strobe.
- The counter, FSM and fault logic stay in the top module.

## Test plan
- Toggle sig_in every 5 clks with defaults:
  - First edge gives no period_valid.
  - Each later edge gives half_period=5.
  - locked=1 at the 4th valid pulse.
  - fault stays 0.
- While locked, stretch one half-period to 7 with TOL=0: period_valid with half_period=7, fault=1, locked=0, state MEASURE; relock after 4 good periods.
- Hold sig_in constant while locked: fault=1 and locked=0 exactly TIMEOUT+1 cycles after the last edge; the next edge produces no measurement.
- Set TOL=1 and alternate half-periods 4 and 6: lock is achieved; half-period 7 sets fault.
- Pulse clr_fault while fault=1 and no new error: fault=0 next cycle. Pulse clr_fault in the same cycle as a tolerance error: fault remains 1.
- Assert rst=0 for 1 cycle mid-interval while locked: all outputs 0 and state SEARCH; run the latency check with and without CLK_PERIOD_MONITOR_SYNC_EN (3 vs 1 cycle).

Source files
------------

// File: rtl/clk_mon_pkg.sv
// ---------------------------------------------------------------------------
// clk_mon_pkg: shared FSM state encoding and default widths for clk_period_monitor.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package clk_mon_pkg;

  localparam int CNT_W_DEF = 32;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } mon_state_t;

endpackage

`default_nettype wire

// File: rtl/sync_edge_det.sv
// ---------------------------------------------------------------------------
// sync_edge_det: optional 2-flop synchronizer (CLK_PERIOD_MONITOR_SYNC_EN) plus edge strobe.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sync_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic sig_in,
  output logic s,
  output logic edge_stb
);

`ifdef CLK_PERIOD_MONITOR_SYNC_EN
  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= sig_in;
      r_sync <= r_meta;
    end
  end

  assign s = r_sync;
`else
  assign s = sig_in;
`endif

  logic r_prev;

  always_ff @(posedge clk) begin
    if (!rst) r_prev <= 1'b0;
    else      r_prev <= s;
  end

  assign edge_stb = s ^ r_prev;

endmodule

`default_nettype wire

// File: rtl/clk_period_monitor.sv
// ---------------------------------------------------------------------------
// clk_period_monitor: half-period measurement, lock tracking and sticky fault (CLK_PERIOD_MONITOR_SYNC_EN).
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module clk_period_monitor
  import clk_mon_pkg::*;
#(
  parameter int EXP_HALF = 5,
  parameter int TOL      = 0,
  parameter int LOCK_CNT = 4,
  parameter int TIMEOUT  = 1023,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             clr_fault,
  output logic [CNT_W-1:0] half_period,
  output logic             period_valid,
  output logic             edge_pulse,
  output logic             locked,
  output logic             fault
);

  localparam logic [CNT_W-1:0]     C_TIMEOUT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0]     C_LOCK    = CNT_W'(LOCK_CNT);
  localparam logic signed [CNT_W:0] C_EXP    = (CNT_W+1)'(EXP_HALF);
  localparam logic signed [CNT_W:0] C_TOL    = (CNT_W+1)'(TOL);

  logic                    w_s_unused;
  logic                    w_edge;
  logic [CNT_W-1:0]        r_cnt;
  logic [CNT_W-1:0]        w_meas;
  logic signed [CNT_W:0]   w_diff;
  logic signed [CNT_W:0]   w_abs;
  logic                    w_in_tol;
  logic                    w_timeout;
  mon_state_t              r_state;
  mon_state_t              w_state_nxt;
  logic [CNT_W-1:0]        r_match_cnt;
  logic [CNT_W-1:0]        w_match_nxt;
  logic                    w_fault_set;
  logic                    w_meas_valid;

  sync_edge_det u_sync_edge_det (
    .clk      (clk),
    .rst      (rst),
    .sig_in   (sig_in),
    .s        (w_s_unused),
    .edge_stb (w_edge)
  );

  always_ff @(posedge clk) begin
    if (!rst)                     r_cnt <= '0;
    else if (w_edge)              r_cnt <= '0;
    else if (r_cnt != C_TIMEOUT)  r_cnt <= r_cnt + CNT_W'(1);
  end

  assign w_meas   = r_cnt + CNT_W'(1);
  assign w_diff   = $signed({1'b0, w_meas}) - C_EXP;
  assign w_abs    = w_diff[CNT_W] ? -w_diff : w_diff;
  assign w_in_tol = (w_abs <= C_TOL);
  // An edge arriving while the counter sits at TIMEOUT still counts as an edge.
  assign w_timeout = (r_cnt == C_TIMEOUT) && !w_edge;

  always_comb begin
    w_state_nxt  = r_state;
    w_match_nxt  = r_match_cnt;
    w_fault_set  = 1'b0;
    w_meas_valid = 1'b0;
    if (w_timeout) begin
      w_state_nxt = SEARCH;
      w_match_nxt = '0;
      w_fault_set = (r_state != SEARCH);
    end else if (w_edge) begin
      unique case (r_state)
        SEARCH: w_state_nxt = MEASURE;
        MEASURE: begin
          w_meas_valid = 1'b1;
          if (w_in_tol) begin
            w_match_nxt = r_match_cnt + CNT_W'(1);
            if (r_match_cnt + CNT_W'(1) == C_LOCK) w_state_nxt = LOCKED;
          end else begin
            w_match_nxt = '0;
          end
        end
        LOCKED: begin
          w_meas_valid = 1'b1;
          if (!w_in_tol) begin
            w_fault_set = 1'b1;
            w_match_nxt = '0;
            w_state_nxt = MEASURE;
          end
        end
        default: w_state_nxt = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) r_state <= SEARCH;
    else      r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_match_cnt  <= '0;
      half_period  <= '0;
      period_valid <= 1'b0;
      edge_pulse   <= 1'b0;
      fault        <= 1'b0;
    end else begin
      r_match_cnt  <= w_match_nxt;
      period_valid <= w_meas_valid;
      edge_pulse   <= w_edge;
      if (w_meas_valid) half_period <= w_meas;
      if (w_fault_set)    fault <= 1'b1;
      else if (clr_fault) fault <= 1'b0;
    end
  end

  assign locked = (r_state == LOCKED);

endmodule

`default_nettype wire

// File: tb/tb_clk_period_monitor.sv
// ---------------------------------------------------------------------------
// tb_clk_period_monitor: directed stimulus with a scoreboard for clk_period_monitor.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_clk_period_monitor;

  localparam int TIMEOUT = 1023;
  localparam int CNT_W   = 32;
`ifdef CLK_PERIOD_MONITOR_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic             clk;
  logic             rst;
  logic             sig_in;
  logic             clr_fault;
  logic [CNT_W-1:0] half_period, half_period_t1;
  logic             period_valid, period_valid_t1;
  logic             edge_pulse, edge_pulse_t1;
  logic             locked, locked_t1;
  logic             fault, fault_t1;

  clk_period_monitor #(
    .EXP_HALF(5), .TOL(0), .LOCK_CNT(4), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .sig_in(sig_in), .clr_fault(clr_fault),
    .half_period(half_period), .period_valid(period_valid),
    .edge_pulse(edge_pulse), .locked(locked), .fault(fault)
  );

  clk_period_monitor #(
    .EXP_HALF(5), .TOL(1), .LOCK_CNT(4), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
  ) dut_t1 (
    .clk(clk), .rst(rst), .sig_in(sig_in), .clr_fault(clr_fault),
    .half_period(half_period_t1), .period_valid(period_valid_t1),
    .edge_pulse(edge_pulse_t1), .locked(locked_t1), .fault(fault_t1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int hp;
    bit lk;
    bit ft;
  } exp_t;

  exp_t sb_q[$];
  int   checks     = 0;
  int   failures   = 0;
  int   edges_exp  = 0;
  int   edges_seen = 0;

  function automatic void chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, req, $time);
    end
  endfunction

  // Wait gap cycles, toggle sig_in, and queue the measurement it should produce.
  task automatic step(input int gap, input bit has_meas, input int hp, input bit lk, input bit ft);
    exp_t e;
    repeat (gap) @(negedge clk);
    sig_in = ~sig_in;
    edges_exp++;
    if (has_meas) begin
      e.hp = hp;
      e.lk = lk;
      e.ft = ft;
      sb_q.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (edge_pulse) edges_seen++;
    if (period_valid) begin
      chk("pv_with_edge_pulse", edge_pulse, 1);
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_period_valid: got half_period=%0d, required no pulse (t=%0t)",
                 half_period, $time);
      end else begin
        e = sb_q.pop_front();
        chk("half_period", half_period, e.hp);
        chk("locked_at_pv", locked, e.lk);
        chk("fault_at_pv", fault, e.ft);
      end
    end
  end

  initial begin
    int n;
    sig_in    = 1'b0;
    clr_fault = 1'b0;
    rst       = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_half_period", half_period, 0);
    chk("rst_period_valid", period_valid, 0);
    chk("rst_edge_pulse", edge_pulse, 0);
    chk("rst_locked", locked, 0);
    chk("rst_fault", fault, 0);
    rst = 1'b1;

    // Lock on a steady 5-cycle toggle; first edge is partial.
    step(5, 0, 0, 0, 0);
    repeat (3) step(5, 1, 5, 0, 0);
    repeat (3) step(5, 1, 5, 1, 0);

    // Stretched half-period while locked, then relock.
    step(7, 1, 7, 0, 1);
    repeat (3) step(5, 1, 5, 0, 1);
    step(5, 1, 5, 1, 1);

    // Plain clear.
    repeat (LAT) @(negedge clk);
    clr_fault = 1'b1;
    @(negedge clk);
    clr_fault = 1'b0;
    chk("clr_fault_clears", fault, 0);
    step(4 - LAT, 1, 5, 1, 0);

    // Clear coinciding with a tolerance error: set wins.
    step(7, 1, 7, 0, 1);
    repeat (LAT - 1) @(negedge clk);
    clr_fault = 1'b1;
    @(negedge clk);
    clr_fault = 1'b0;
    @(negedge clk);
    chk("fault_set_beats_clr", fault, 1);
    step(4 - LAT, 1, 5, 0, 1);
    repeat (2) step(5, 1, 5, 0, 1);
    repeat (2) step(5, 1, 5, 1, 1);

    // Timeout while locked.
    repeat (LAT) @(negedge clk);
    clr_fault = 1'b1;
    @(negedge clk);
    clr_fault = 1'b0;
    chk("clr_before_timeout", fault, 0);
    repeat (TIMEOUT - 1) @(negedge clk);
    chk("fault_before_timeout", fault, 0);
    chk("locked_before_timeout", locked, 1);
    @(negedge clk);
    chk("fault_at_timeout", fault, 1);
    chk("locked_at_timeout", locked, 0);
    step(5, 0, 0, 0, 0);
    repeat (3) step(5, 1, 5, 0, 1);
    step(5, 1, 5, 1, 1);

    // Reset mid-interval while locked.
    repeat (LAT + 1) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_half_period", half_period, 0);
    chk("midrst_period_valid", period_valid, 0);
    chk("midrst_edge_pulse", edge_pulse, 0);
    chk("midrst_locked", locked, 0);
    chk("midrst_fault", fault, 0);
    chk("midrst_locked_t1", locked_t1, 0);
    rst = 1'b1;

    // Edge latency from the first sampling clock edge.
    repeat (3) @(negedge clk);
    sig_in = 1'b1;
    edges_exp++;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n++;
      if (edge_pulse) break;
    end
    chk("edge_latency", n, LAT);
    chk("search_edge_no_pv", period_valid, 0);

    // TOL=1 instance: alternate 4/6 locks, 7 faults; TOL=0 instance stays unlocked.
    step((4 - n) < 1 ? 1 : (4 - n), 1, 4, 0, 0);
    step(6, 1, 6, 0, 0);
    step(4, 1, 4, 0, 0);
    step(6, 1, 6, 0, 0);
    repeat (LAT) @(negedge clk);
    chk("t1_locked", locked_t1, 1);
    chk("t1_fault_clear", fault_t1, 0);
    chk("t1_half_period_6", half_period_t1, 6);
    step(7 - LAT, 1, 7, 0, 0);
    repeat (LAT) @(negedge clk);
    chk("t1_fault_on_7", fault_t1, 1);
    chk("t1_unlocked_on_7", locked_t1, 0);
    chk("t1_half_period_7", half_period_t1, 7);

    repeat (LAT + 2) @(negedge clk);
    chk("scoreboard_drained", sb_q.size(), 0);
    chk("edge_pulse_count", edges_seen, edges_exp);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: got timeout at t=%0t required completion", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
